// File: rtl/gray_step_monitor_if.sv
// Count-stream link between the binary up-counter and the Gray step monitor.
// The counter side drives bin_in/bin_valid; the monitor returns Gray code and status.
interface gray_step_monitor_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] bin_in;
    logic             bin_valid;
    logic [WIDTH-1:0] gray_out;
    logic             gray_valid;
    logic             wrap;
    logic             step_err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;
    logic             locked;

    modport master (
        output bin_in, bin_valid,
        input  gray_out, gray_valid, wrap, step_err, err_sticky, err_count, locked
    );

    modport slave (
        input  bin_in, bin_valid,
        output gray_out, gray_valid, wrap, step_err, err_sticky, err_count, locked
    );
endinterface

// File: rtl/gray_step_monitor.sv
// Registers the Gray code of an up-counter and checks that successive samples move by one bit,
// with a lock FSM, wrap detection and saturating error statistics.
//
// state   | meaning
// IDLE    | waiting for the first sample to seed the previous-value register
// ACQUIRE | counting consecutive single-bit steps towards lock
// LOCKED  | stream stepping cleanly; a multi-bit jump is an error
// FAULT   | error seen; further jumps counted until a clean step resumes acquisition
module gray_step_monitor #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int LOCK_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    gray_step_monitor_if.slave mon
);
    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [GW-1:0]    LOCK_CNT = GW'(LOCK_N);
    localparam logic [WIDTH-1:0] GRAY_TOP = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

    state_t           state, state_nxt;
    logic [GW-1:0]    good_cnt, good_cnt_nxt;
    logic [WIDTH-1:0] prev, gray_nxt, diff;
    logic [WIDTH-1:0] gray_q;
    logic             gray_valid_q, wrap_q, step_err_q, err_sticky_q;
    logic [ERR_W-1:0] err_count_q;
    logic             accept, step_one, step_multi;
    logic             err_nxt, wrap_nxt;

    assign accept   = mon.bin_valid & ~clr;
    assign gray_nxt = mon.bin_in ^ (mon.bin_in >> 1);
    assign diff     = gray_nxt ^ prev;
    // A nonzero power of two differs in exactly one bit.
    assign step_one   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign step_multi = (diff != '0) && !step_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else if (clr) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        err_nxt      = 1'b0;
        wrap_nxt     = 1'b0;
        if (accept) begin
            wrap_nxt = (state != IDLE) && (prev == GRAY_TOP) && (gray_nxt == '0);
            case (state)
                IDLE: begin
                    good_cnt_nxt = '0;
                    state_nxt    = ACQUIRE;
                end
                ACQUIRE: begin
                    if (step_one) begin
                        if (good_cnt >= LOCK_CNT - GW'(1)) begin
                            good_cnt_nxt = LOCK_CNT;
                            state_nxt    = LOCKED;
                        end else begin
                            good_cnt_nxt = good_cnt + GW'(1);
                        end
                    end else if (step_multi) begin
                        good_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (step_multi) begin
                        err_nxt   = 1'b1;
                        state_nxt = FAULT;
                    end
                end
                FAULT: begin
                    if (step_multi) begin
                        err_nxt = 1'b1;
                    end else if (step_one) begin
                        good_cnt_nxt = GW'(1);
                        state_nxt    = ACQUIRE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // prev is deliberately kept across clr: the IDLE capture overwrites it before it is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev         <= '0;
            gray_q       <= '0;
            gray_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else if (clr) begin
            gray_q       <= '0;
            gray_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            gray_valid_q <= accept;
            wrap_q       <= wrap_nxt;
            step_err_q   <= err_nxt;
            if (accept) begin
                prev   <= gray_nxt;
                gray_q <= gray_nxt;
            end
            if (err_nxt) begin
                err_sticky_q <= 1'b1;
                if (err_count_q != '1) begin
                    err_count_q <= err_count_q + ERR_W'(1);
                end
            end
        end
    end

    always_comb begin
        mon.locked     = (state == LOCKED);
        mon.gray_out   = gray_q;
        mon.gray_valid = gray_valid_q;
        mon.wrap       = wrap_q;
        mon.step_err   = step_err_q;
        mon.err_sticky = err_sticky_q;
        mon.err_count  = err_count_q;
    end
endmodule

// File: doc/gray_step_monitor.md
# gray_step_monitor

Downstream stage for the 4-bit up-counter: it takes the counter's binary value, converts it to Gray code and registers it. It also checks that successive Gray samples differ in exactly one bit. A lock state machine reports whether the count stream is stepping cleanly, pulses on wrap-around, and keeps saturating error statistics for the counter's reset/set jumps or glitches.

## Interface
- WIDTH, 4, width of the binary input and Gray output
- ERR_W, 8, width of the saturating error counter
- LOCK_N, 3, consecutive good steps (1 to 2^WIDTH-1) needed to declare lock
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high; forces every register to its reset value immediately
- clr  in  1  synchronous clear of state machine, statistics and outputs
- bin_in  in  WIDTH  binary count from the counter
- bin_valid  in  1  bin_in is sampled on this edge
- gray_out  out  WIDTH  registered Gray code of the last accepted sample, gray = b ^ (b >> 1)
- gray_valid  out  1  registered copy of the accept strobe
- wrap  out  1  one-cycle pulse: accepted sample went from Gray of 2^WIDTH-1 to 0
- step_err  out  1  one-cycle pulse: illegal step counted
- err_sticky  out  1  set on first counted error, held until rst/clr
- err_count  out  ERR_W  counted errors, saturating at 2^ERR_W-1
- locked  out  1  high while FSM is in LOCKED

## Operation
- Reset values: gray_out=0, gray_valid=0, wrap=0, step_err=0, err_sticky=0, err_count=0, locked=0, FSM=IDLE, good_cnt=0, prev register=0.
- Accept = bin_valid & ~clr. On accept: g = gray(bin_in), d = popcount(g ^ prev), prev <= g, gray_out <= g.
- clr has priority over bin_valid. It returns FSM to IDLE, zeroes good_cnt, err_count, err_sticky, gray_out and gray_valid, and drops any sample presented in that cycle.
- FSM states: IDLE, ACQUIRE, LOCKED, FAULT. Transitions are evaluated on accepted samples only; without accept, the state and good_cnt hold.
- IDLE: first accept captures prev, sets good_cnt=0 and goes to ACQUIRE. d is not evaluated and no wrap is reported.
- ACQUIRE:
  - d=1: good_cnt++. When good_cnt reaches LOCK_N, go to LOCKED.
  - d=0 (stall): no change.
  - d>1: good_cnt=0, stay in ACQUIRE, no error counted.
- LOCKED:
  - d=1 or d=0: stay.
  - d>1: step_err pulse, err_count++ (saturating), err_sticky=1, go to FAULT.
- FAULT:
  - d>1: step_err pulse and err_count++ again, stay in FAULT.
  - d=1: good_cnt=1, go to ACQUIRE.
  - d=0: stay.
- wrap: in any state except IDLE, accepted sample with prev = gray(2^WIDTH-1) and g = 0. For WIDTH=4 this is 1000 -> 0000. The d=1 rules still apply to this step.
- good_cnt is wide enough for LOCK_N and does not exceed it.

## Timing
- Latency is 1 cycle. gray_out, gray_valid, wrap, step_err and locked all update on the same edge that accepts the sample.
- wrap and step_err are high for exactly one cycle per causing sample. Back-to-back causes give back-to-back pulses.
- locked rises on the edge that accepts the LOCK_N-th good step. It falls on the edge that accepts the faulting sample.
- The err_count increment and err_sticky set are visible in the same cycle as step_err.
- rst asserted between edges clears all outputs without a clock edge. The first accept after rst deassertion is treated as the IDLE capture.

## Test plan
- rst, then bin_in 0,1,2,3 valid on consecutive cycles:
  - gray_out reads 0000,0001,0011,0010, each one cycle after its input.
  - locked=1 in the same cycle as gray_out=0010.
  - step_err never asserts.
- While locked, feed 14,15,0:
  - gray_out reads 1001,1000,0000.
  - wrap=1 only with 0000.
  - err_count stays 0 and locked stays 1.
- While locked at 5, feed 15, then 0,1,2:
  - The 15 gives step_err=1, err_count=1, err_sticky=1 and locked=0 with gray_out=1000.
  - The 0 gives wrap=1; 1 and 2 are further good steps.
  - locked returns to 1 with gray_out=0011.
- Hold bin_in=7 valid for 5 cycles while locked: gray_valid=1 and gray_out=0100 every cycle, no step_err, locked stays 1.
- Alternate bin_in 0 and 5 for 300 accepted samples after lock:
  - Gray values are 0000 and 0111 (d=3).
  - step_err pulses on every sample after the first.
  - err_count saturates at 255 and holds, err_sticky=1.
- Reset and clear behaviour:
  - Assert rst mid-stream off a clock edge: all outputs read 0 immediately.
  - Assert clr together with bin_valid and bin_in=9: the sample is dropped, gray_valid=0, and err_count and err_sticky are 0.
  - The next accept produces no wrap or error.
